// File: rtl/cpu_memory_responder.sv
// ============================================================
// Module : cpu_memory_responder
// Harvard I/D RAM responder with a posted-store write buffer.
// Rev    : 1.0
// ============================================================
`default_nettype none

module cpu_memory_responder #(
  parameter int IMEM_WORDS = 1024,
  parameter int DMEM_WORDS = 1024,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [31:0]                       instr_addr,
  output logic [31:0]                       instruction,
  input  logic [31:0]                       data_addr,
  input  logic [31:0]                       data_write,
  input  logic                              mem_write_en,
  input  logic                              mem_read_en,
  output logic [31:0]                       data_read,
  input  logic                              imem_we,
  input  logic [31:0]                       imem_waddr,
  input  logic [31:0]                       imem_wdata,
  output logic [$clog2(WBUF_DEPTH+1)-1:0]   wbuf_count,
  output logic                              wbuf_empty,
  output logic [2:0]                        err_status
);

  localparam int c_IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int c_DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam int c_PW  = $clog2(WBUF_DEPTH);
  localparam int c_CW  = $clog2(WBUF_DEPTH+1);
  localparam logic [31:0]     c_NOP     = 32'h0000_0013;
  localparam logic [c_CW-1:0] c_CONE    = c_CW'(1);
  localparam logic [c_CW-1:0] c_CFULL   = c_CW'(WBUF_DEPTH);
  localparam logic [c_PW-1:0] c_PONE    = c_PW'(1);
  localparam logic [c_PW-1:0] c_PLAST   = c_PW'(WBUF_DEPTH-1);
  localparam logic [c_PW:0]   c_WDEPTH  = (c_PW+1)'(WBUF_DEPTH);

  logic [31:0] r_imem [IMEM_WORDS];
  logic [31:0] r_dmem [DMEM_WORDS];

  logic [c_DAW-1:0] r_bidx [WBUF_DEPTH];
  logic [31:0]      r_bdat [WBUF_DEPTH];
  logic [c_PW-1:0]  r_head;
  logic [c_PW-1:0]  r_tail;
  logic [c_CW-1:0]  r_count;
  logic             r_empty;
  logic [2:0]       r_err;

  function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
    return (p == c_PLAST) ? '0 : p + c_PONE;
  endfunction

  // ---------------- instruction side ----------------
  logic [29:0] w_iidx;
  logic        w_ivalid;
  logic [29:0] w_lidx;
  logic        w_lvalid;

  assign w_iidx   = instr_addr[31:2];
  assign w_ivalid = (instr_addr[1:0] == 2'b00) && ({2'b00, w_iidx} < 32'(IMEM_WORDS));
  assign w_lidx   = imem_waddr[31:2];
  assign w_lvalid = (imem_waddr[1:0] == 2'b00) && ({2'b00, w_lidx} < 32'(IMEM_WORDS));

  assign instruction = (!reset_n || !w_ivalid) ? c_NOP : r_imem[w_iidx[c_IAW-1:0]];

  always_ff @(posedge clk) begin
    if (imem_we && w_lvalid) begin
      r_imem[w_lidx[c_IAW-1:0]] <= imem_wdata;
    end
  end

  // ---------------- data side ----------------
  logic [29:0] w_didx;
  logic        w_mis;
  logic        w_oor;
  logic        w_dok;
  logic        w_req;
  logic        w_push;
  logic        w_full;
  logic        w_idle_drain;
  logic        w_pop;

  assign w_didx       = data_addr[31:2];
  assign w_mis        = (data_addr[1:0] != 2'b00);
  assign w_oor        = ({2'b00, w_didx} >= 32'(DMEM_WORDS));
  assign w_dok        = !w_mis && !w_oor;
  assign w_req        = mem_read_en | mem_write_en;
  assign w_push       = mem_write_en & ~mem_read_en & w_dok;
  assign w_full       = (r_count == c_CFULL);
  assign w_idle_drain = (r_count != '0) & ~mem_read_en & ~mem_write_en;
  // A store into a full buffer retires the head in the same cycle so the core never stalls.
  assign w_pop        = w_idle_drain | (w_push & w_full);

  // Physical slot of the i-th oldest entry.
  logic [c_PW-1:0] w_slot [WBUF_DEPTH];

  for (genvar g = 0; g < WBUF_DEPTH; g++) begin : g_slot
    logic [c_PW:0] w_sum;
    assign w_sum     = {1'b0, r_head} + (c_PW+1)'(g);
    assign w_slot[g] = (w_sum >= c_WDEPTH) ? c_PW'(w_sum - c_WDEPTH) : w_sum[c_PW-1:0];
  end

  logic        w_hit;
  logic [31:0] w_fwd;

  // Scan oldest to youngest; the last match wins.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if ((c_CW'(i) < r_count) && (r_bidx[w_slot[i]] == w_didx[c_DAW-1:0])) begin
        w_hit = 1'b1;
        w_fwd = r_bdat[w_slot[i]];
      end
    end
  end

  assign data_read = (reset_n && mem_read_en && w_dok)
                   ? (w_hit ? w_fwd : r_dmem[w_didx[c_DAW-1:0]])
                   : '0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_bidx[r_tail] <= w_didx[c_DAW-1:0];
      r_bdat[r_tail] <= data_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && w_pop) begin
      r_dmem[r_bidx[r_head]] <= r_bdat[r_head];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_err   <= '0;
    end else begin
      r_err <= r_err | {mem_read_en & mem_write_en, w_req & w_oor, w_req & w_mis};
      if (w_push) r_tail <= f_next(r_tail);
      if (w_pop)  r_head <= f_next(r_head);
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CONE;
        r_empty <= 1'b0;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CONE;
        r_empty <= (r_count == c_CONE);
      end
    end
  end

  assign wbuf_count = r_count;
  assign wbuf_empty = r_empty;
  assign err_status = r_err;

endmodule

`default_nettype wire

// File: tb/tb_cpu_memory_responder.sv
// ============================================================
// Module : tb_cpu_memory_responder
// Directed + random bench with a queue-based memory reference model.
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_cpu_memory_responder;

  localparam int IMW = 32;
  localparam int DMW = 64;
  localparam int WD  = 4;
  localparam int CW  = $clog2(WD+1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   instr_addr;
  logic [31:0]   instruction;
  logic [31:0]   data_addr;
  logic [31:0]   data_write;
  logic          mem_write_en;
  logic          mem_read_en;
  logic [31:0]   data_read;
  logic          imem_we;
  logic [31:0]   imem_waddr;
  logic [31:0]   imem_wdata;
  logic [CW-1:0] wbuf_count;
  logic          wbuf_empty;
  logic [2:0]    err_status;

  always #5 clk = ~clk;

  cpu_memory_responder #(
    .IMEM_WORDS(IMW),
    .DMEM_WORDS(DMW),
    .WBUF_DEPTH(WD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_addr(instr_addr), .instruction(instruction),
    .data_addr(data_addr), .data_write(data_write),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .data_read(data_read),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .wbuf_count(wbuf_count), .wbuf_empty(wbuf_empty), .err_status(err_status)
  );

  typedef struct packed { logic [31:0] idx; logic [31:0] data; } ent_t;
  ent_t        wq[$];
  logic [31:0] dm [DMW];
  logic [31:0] im [IMW];
  logic [2:0]  em;
  int          checks = 0;
  int          passes = 0;
  logic [31:0] pre [3];

  function automatic logic [31:0] widx(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_load();
    if (!reset_n || !mem_read_en) return 32'h0;
    if (data_addr[1:0] != 2'b00 || widx(data_addr) >= 32'(DMW)) return 32'h0;
    for (int i = wq.size() - 1; i >= 0; i--)
      if (wq[i].idx == widx(data_addr)) return wq[i].data;
    return dm[int'(widx(data_addr))];
  endfunction

  function automatic logic [31:0] exp_instr();
    if (!reset_n) return NOP;
    if (instr_addr[1:0] != 2'b00 || widx(instr_addr) >= 32'(IMW)) return NOP;
    return im[int'(widx(instr_addr))];
  endfunction

  // Reference behaviour of one clock edge, from the current inputs.
  task automatic model_edge();
    logic mis, oor, ok;
    if (imem_we && imem_waddr[1:0] == 2'b00 && widx(imem_waddr) < 32'(IMW))
      im[int'(widx(imem_waddr))] = imem_wdata;
    if (!reset_n) begin
      wq.delete();
      em = 3'b000;
      return;
    end
    mis = (data_addr[1:0] != 2'b00);
    oor = (widx(data_addr) >= 32'(DMW));
    ok  = !mis && !oor;
    if (mem_read_en || mem_write_en)
      em = em | {mem_read_en & mem_write_en, oor, mis};
    if (mem_write_en && !mem_read_en && ok) begin
      if (wq.size() == WD) begin
        dm[int'(wq[0].idx)] = wq[0].data;
        void'(wq.pop_front());
      end
      wq.push_back('{idx: widx(data_addr), data: data_write});
    end else if (!mem_write_en && !mem_read_en && wq.size() > 0) begin
      dm[int'(wq[0].idx)] = wq[0].data;
      void'(wq.pop_front());
    end
  endtask

  // Called shortly after a posedge with inputs already driven.
  task automatic cyc(input string tag);
    #2;
    chk({tag, " data_read"}, data_read, exp_load());
    chk({tag, " instruction"}, instruction, exp_instr());
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, " wbuf_count"}, 32'(wbuf_count), 32'(wq.size()));
    chk({tag, " wbuf_empty"}, {31'b0, wbuf_empty}, {31'b0, wq.size() == 0});
    chk({tag, " err_status"}, {29'b0, err_status}, {29'b0, em});
  endtask

  task automatic drv(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    mem_write_en = we;
    mem_read_en  = re;
    data_addr    = a;
    data_write   = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; instr_addr = 32'h0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    drv(1'b0, 1'b1, 32'h0, 32'h0);
    em = 3'b000;
    @(posedge clk); #1;
    #1 chk("reset nop", instruction, NOP);
    chk("reset data_read", data_read, 32'h0);
    cyc("reset");
    reset_n = 1'b1;

    // Preload both RAMs so every later read has a known value.
    instr_addr = IMW * 4;
    for (int i = 0; i < IMW; i++) begin
      imem_we = 1'b1; imem_waddr = i * 4; imem_wdata = $urandom;
      drv(1'b0, 1'b0, 32'h0, 32'h0);
      cyc("init imem");
    end
    imem_we = 1'b0;
    for (int i = 0; i < DMW; i++) begin
      drv(1'b1, 1'b0, i * 4, $urandom);
      cyc("init dmem");
    end
    for (int i = 0; i < WD; i++) begin
      drv(1'b0, 1'b0, 32'h0, 32'h0);
      cyc("init drain");
    end

    // 1: forward then drain
    drv(1'b1, 1'b0, 32'h40, 32'hDEADBEEF); cyc("t1 store");
    drv(1'b0, 1'b1, 32'h40, 32'h0);
    #2 chk("t1 fwd", data_read, 32'hDEADBEEF);
    chk("t1 count1", 32'(wbuf_count), 32'd1);
    cyc("t1 load");
    drv(1'b0, 1'b0, 32'h0, 32'h0); cyc("t1 idle");
    chk("t1 count0", 32'(wbuf_count), 32'd0);
    drv(1'b0, 1'b1, 32'h40, 32'h0);
    #2 chk("t1 ram", data_read, 32'hDEADBEEF);
    cyc("t1 ram load");

    // 2: overflow force-drain
    for (int k = 1; k <= 5; k++) begin
      drv(1'b1, 1'b0, (k - 1) * 4, k);
      cyc("t2 store");
      chk("t2 count", 32'(wbuf_count), (k < WD) ? k : WD);
    end
    drv(1'b0, 1'b1, 32'h0, 32'h0);
    #2 chk("t2 dmem0", data_read, 32'h1);
    cyc("t2 load0");
    for (int i = 0; i < WD; i++) begin
      drv(1'b0, 1'b0, 32'h0, 32'h0); cyc("t2 idle");
    end
    chk("t2 empty", {31'b0, wbuf_empty}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      drv(1'b0, 1'b1, (k - 1) * 4, 32'h0);
      #2 chk("t2 readback", data_read, k);
      cyc("t2 readback");
    end

    // 3: duplicate index, youngest wins
    drv(1'b1, 1'b0, 32'h10, 32'h1111); cyc("t3 st1");
    drv(1'b1, 1'b0, 32'h10, 32'h2222); cyc("t3 st2");
    drv(1'b0, 1'b1, 32'h10, 32'h0);
    #2 chk("t3 fwd", data_read, 32'h2222);
    cyc("t3 load");
    for (int i = 0; i < 2; i++) begin
      drv(1'b0, 1'b0, 32'h0, 32'h0); cyc("t3 idle");
    end
    drv(1'b0, 1'b1, 32'h10, 32'h0);
    #2 chk("t3 ram", data_read, 32'h2222);
    cyc("t3 ram load");

    // 4: errors
    drv(1'b1, 1'b0, 32'h42, 32'h5555); cyc("t4 mis");
    chk("t4 err001", {29'b0, err_status}, 32'b001);
    chk("t4 count", 32'(wbuf_count), 32'd0);
    drv(1'b0, 1'b1, DMW * 4, 32'h0);
    #2 chk("t4 oor data", data_read, 32'h0);
    cyc("t4 oor");
    chk("t4 err011", {29'b0, err_status}, 32'b011);
    drv(1'b1, 1'b1, 32'h20, 32'h7777); cyc("t4 coll");
    chk("t4 err2", {31'b0, err_status[2]}, 32'd1);

    // 5: reset discards buffered stores
    for (int k = 0; k < 3; k++) begin
      pre[k] = dm[32 + k];
      drv(1'b1, 1'b0, 32'h80 + k * 4, 32'hA000_0000 + k);
      cyc("t5 store");
    end
    chk("t5 count3", 32'(wbuf_count), 32'd3);
    reset_n = 1'b0; drv(1'b0, 1'b0, 32'h0, 32'h0); cyc("t5 reset");
    reset_n = 1'b1;
    chk("t5 count0", 32'(wbuf_count), 32'd0);
    chk("t5 err0", {29'b0, err_status}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drv(1'b0, 1'b1, 32'h80 + k * 4, 32'h0);
      #2 chk("t5 old", data_read, pre[k]);
      cyc("t5 load");
    end

    // 6: instruction RAM load port
    drv(1'b0, 1'b0, 32'h0, 32'h0);
    imem_we = 1'b1; imem_waddr = 32'h8; imem_wdata = 32'h0050_0093; instr_addr = 32'h8;
    cyc("t6 load same");
    imem_we = 1'b0;
    #2 chk("t6 new", instruction, 32'h0050_0093);
    cyc("t6 fetch");
    instr_addr = IMW * 4;
    #2 chk("t6 oor", instruction, NOP);
    cyc("t6 oor");
    instr_addr = 32'h8; reset_n = 1'b0;
    #2 chk("t6 reset nop", instruction, NOP);
    cyc("t6 reset");
    reset_n = 1'b1;

    // Random traffic on a small index set to exercise forwarding and wrap.
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [31:0] a;
      reset_n = ($urandom_range(0, 39) != 0);
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 7) * 4;
      if ($urandom_range(0, 9) == 0) a = a + $urandom_range(1, 3);
      if ($urandom_range(0, 19) == 0) a = (DMW + $urandom_range(0, 3)) * 4;
      drv(r < 3 || r == 6, r >= 3 && r <= 6, a, $urandom);
      imem_we    = ($urandom_range(0, 4) == 0);
      imem_waddr = $urandom_range(0, IMW + 2) * 4 + (($urandom_range(0, 9) == 0) ? 1 : 0);
      imem_wdata = $urandom;
      instr_addr = $urandom_range(0, IMW + 2) * 4 + (($urandom_range(0, 9) == 0) ? 2 : 0);
      cyc("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
